fb_write_arbiter: RTL and testbench

- Sequences and shares the single write port of the 240x160 RGB6 (18-bit) GBA frame buffer among three requesters.
- Requester 1: the GBA pixel stream, which has no backpressure and highest priority.
- Requester 2: a host writer using a valid/ready handshake.
- Requester 3: an internal rectangle-fill engine, used for clear-screen, letterbox and splash fills.
- The block sits in the GBA clock domain and drives the frame buffer's port A directly. Its output is a registered address/data/write-enable triple.

---
 rtl/fb_write_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Write-port arbiter for the 240x160 RGB6 GBA frame buffer: GBA pixel stream > host writer > rectangle fill.
// Output is a registered we/addr/data triple with one cycle of latency.
module fb_write_arbiter #(
  parameter int WIDTH       = 240,
  parameter int HEIGHT      = 160,
  parameter int COLOR_WIDTH = 18,
  parameter int AWIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   gba_we,
  input  logic [7:0]             gba_x,
  input  logic [7:0]             gba_y,
  input  logic [COLOR_WIDTH-1:0] gba_data,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [7:0]             host_x,
  input  logic [7:0]             host_y,
  input  logic [COLOR_WIDTH-1:0] host_data,
  input  logic                   fill_start,
  input  logic                   fill_abort,
  input  logic [7:0]             fill_x0,
  input  logic [7:0]             fill_y0,
  input  logic [8:0]             fill_w,
  input  logic [8:0]             fill_h,
  input  logic [COLOR_WIDTH-1:0] fill_color,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic                   oob_err,
  output logic                   fb_we,
  output logic [AWIDTH-1:0]      fb_addr,
  output logic [COLOR_WIDTH-1:0] fb_wdata
);

  localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
  localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic [7:0]             fx0;
  logic [7:0]             cx;
  logic [7:0]             cy;
  logic [8:0]             xend;
  logic [8:0]             yend;
  logic [COLOR_WIDTH-1:0] fcolor;

  logic                   gba_grant;
  logic                   host_grant;
  logic                   fill_grant;
  logic                   any_grant;
  logic                   fill_load;
  logic                   done_next;
  logic                   degenerate;
  logic                   cx_at_end;
  logic                   cy_at_end;
  logic [9:0]             x_sum;
  logic [9:0]             y_sum;
  logic [8:0]             xend_calc;
  logic [8:0]             yend_calc;
  logic [7:0]             req_x;
  logic [7:0]             req_y;
  logic [COLOR_WIDTH-1:0] req_data;
  logic                   in_range;
  logic [AWIDTH-1:0]      req_y_ext;
  logic [AWIDTH-1:0]      req_addr;

  assign host_ready = ~gba_we;
  assign gba_grant  = gba_we;
  assign host_grant = host_valid & ~gba_we;
  assign fill_grant = (state == RUN) & ~gba_we & ~host_valid;
  assign any_grant  = gba_grant | host_grant | fill_grant;
  assign fill_busy  = (state == RUN);

  // Clip the fill rectangle to the frame at start so the cursor never leaves the buffer.
  always_comb begin
    x_sum      = {2'b00, fill_x0} + {1'b0, fill_w};
    y_sum      = {2'b00, fill_y0} + {1'b0, fill_h};
    xend_calc  = (x_sum > WIDTH_L)  ? WIDTH_L[8:0]  : x_sum[8:0];
    yend_calc  = (y_sum > HEIGHT_L) ? HEIGHT_L[8:0] : y_sum[8:0];
    degenerate = (fill_w == 9'd0) || (fill_h == 9'd0) ||
                 ({2'b00, fill_x0} >= WIDTH_L) || ({2'b00, fill_y0} >= HEIGHT_L);
  end

  assign cx_at_end = ({1'b0, cx} == (xend - 9'd1));
  assign cy_at_end = ({1'b0, cy} == (yend - 9'd1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    fill_load  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          if (degenerate) begin
            done_next = 1'b1;
          end else begin
            fill_load  = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        // Abort beats completion so fill_done only ever marks a finished rectangle.
        if (fill_abort) begin
          state_next = IDLE;
        end else if (fill_grant && cx_at_end && cy_at_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fx0    <= '0;
      cx     <= '0;
      cy     <= '0;
      xend   <= '0;
      yend   <= '0;
      fcolor <= '0;
    end else if (fill_load) begin
      fx0    <= fill_x0;
      cx     <= fill_x0;
      cy     <= fill_y0;
      xend   <= xend_calc;
      yend   <= yend_calc;
      fcolor <= fill_color;
    end else if (fill_grant) begin
      if (cx_at_end) begin
        cx <= fx0;
        cy <= cy + 8'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

  always_comb begin
    req_x    = cx;
    req_y    = cy;
    req_data = fcolor;
    if (gba_grant) begin
      req_x    = gba_x;
      req_y    = gba_y;
      req_data = gba_data;
    end else if (host_grant) begin
      req_x    = host_x;
      req_y    = host_y;
      req_data = host_data;
    end
  end

  // y*240 as (y<<8)-(y<<4) keeps the address path multiplier-free.
  assign req_y_ext = AWIDTH'(req_y);
  assign req_addr  = (req_y_ext << 8) - (req_y_ext << 4) + AWIDTH'(req_x);
  assign in_range  = ({2'b00, req_x} < WIDTH_L) && ({2'b00, req_y} < HEIGHT_L);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
      fill_done <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      fb_we     <= 1'b0;
      fill_done <= done_next;
      if (any_grant) begin
        if (in_range) begin
          fb_we    <= 1'b1;
          fb_addr  <= req_addr;
          fb_wdata <= req_data;
        end else begin
          oob_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table for single writes, scoreboard queue for
// every frame-buffer write, and hand-written fill/abort/out-of-range sequences.
module tb_fb_write_arbiter;

  logic        clk;
  logic        resetn;
  logic        gba_we;
  logic [7:0]  gba_x;
  logic [7:0]  gba_y;
  logic [17:0] gba_data;
  logic        host_valid;
  logic        host_ready;
  logic [7:0]  host_x;
  logic [7:0]  host_y;
  logic [17:0] host_data;
  logic        fill_start;
  logic        fill_abort;
  logic [7:0]  fill_x0;
  logic [7:0]  fill_y0;
  logic [8:0]  fill_w;
  logic [8:0]  fill_h;
  logic [17:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        oob_err;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [17:0] fb_wdata;

  fb_write_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .gba_we     (gba_we),
    .gba_x      (gba_x),
    .gba_y      (gba_y),
    .gba_data   (gba_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_x     (host_x),
    .host_y     (host_y),
    .host_data  (host_data),
    .fill_start (fill_start),
    .fill_abort (fill_abort),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .oob_err    (oob_err),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata)
  );

  typedef struct {
    logic        gba_we;
    logic [7:0]  gba_x;
    logic [7:0]  gba_y;
    logic [17:0] gba_data;
    logic        host_valid;
    logic [7:0]  host_x;
    logic [7:0]  host_y;
    logic [17:0] host_data;
    logic        exp_ready;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [17:0] exp_data;
    logic        exp_oob;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [17:0] data;
  } wr_t;

  vec_t vecs[8];
  wr_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cycles = 0;
  int   done_count = 0;
  logic done_we = 1'b0;
  logic [15:0] done_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input int x, input int y);
    return 16'(y * 240 + x);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [17:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    sb_q.push_back(w);
  endtask

  task automatic apply_stimulus(input vec_t v);
    gba_we     = v.gba_we;
    gba_x      = v.gba_x;
    gba_y      = v.gba_y;
    gba_data   = v.gba_data;
    host_valid = v.host_valid;
    host_x     = v.host_x;
    host_y     = v.host_y;
    host_data  = v.host_data;
  endtask

  task automatic clear_inputs();
    gba_we = 0; gba_x = 0; gba_y = 0; gba_data = 0;
    host_valid = 0; host_x = 0; host_y = 0; host_data = 0;
    fill_start = 0; fill_abort = 0; fill_x0 = 0; fill_y0 = 0;
    fill_w = 0; fill_h = 0; fill_color = 0;
  endtask

  // Called at a negedge; returns at the following negedge with fill_start low again.
  task automatic start_fill(input logic [7:0] x0, input logic [7:0] y0, input logic [8:0] w,
                            input logic [8:0] h, input logic [17:0] color);
    fill_x0 = x0; fill_y0 = y0; fill_w = w; fill_h = h; fill_color = color;
    fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
  endtask

  task automatic wait_fill_idle(input string name);
    int n;
    n = 0;
    while (fill_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (fill_busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: fill_busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  // Scoreboard monitor: every fb_we pulse must match the next queued write.
  always @(posedge clk) begin
    #1;
    if (resetn) begin
      if (fb_we) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: got write addr=%0d data=0x%0h, expected no write",
                   fb_addr, fb_wdata);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          if (fb_addr !== e.addr || fb_wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL sb_write: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                     fb_addr, fb_wdata, e.addr, e.data);
          end
        end
      end
      if (fill_busy) busy_cycles++;
      if (fill_done) begin
        done_count++;
        done_we   = fb_we;
        done_addr = fb_addr;
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, 8'd10,  8'd2,   18'h3FFFF, 1'b0, 8'd0,   8'd0,   18'h0,     1'b0, 1'b1, 16'd490,   18'h3FFFF, 1'b0};
    vecs[1] = '{1'b0, 8'd0,   8'd0,   18'h0,     1'b1, 8'd239, 8'd159, 18'h12345, 1'b1, 1'b1, 16'd38399, 18'h12345, 1'b0};
    vecs[2] = '{1'b1, 8'd0,   8'd0,   18'h00001, 1'b1, 8'd5,   8'd5,   18'h2AAAA, 1'b0, 1'b1, 16'd0,     18'h00001, 1'b0};
    vecs[3] = '{1'b0, 8'd0,   8'd0,   18'h0,     1'b1, 8'd100, 8'd50,  18'h2AAAA, 1'b1, 1'b1, 16'd12100, 18'h2AAAA, 1'b0};
    vecs[4] = '{1'b0, 8'd0,   8'd0,   18'h0,     1'b0, 8'd0,   8'd0,   18'h0,     1'b1, 1'b0, 16'd0,     18'h0,     1'b0};
    vecs[5] = '{1'b1, 8'd239, 8'd0,   18'h15555, 1'b0, 8'd0,   8'd0,   18'h0,     1'b0, 1'b1, 16'd239,   18'h15555, 1'b0};
    vecs[6] = '{1'b0, 8'd0,   8'd0,   18'h0,     1'b1, 8'd0,   8'd159, 18'h00F0F, 1'b1, 1'b1, 16'd38160, 18'h00F0F, 1'b0};
    vecs[7] = '{1'b0, 8'd0,   8'd0,   18'h0,     1'b0, 8'd0,   8'd0,   18'h0,     1'b1, 1'b0, 16'd0,     18'h0,     1'b0};

    clear_inputs();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_fb_we", fb_we, 0);
    check_output("reset_fb_addr", fb_addr, 0);
    resetn = 1'b1;
    @(negedge clk);
    check_output("reset_fb_wdata", fb_wdata, 0);
    check_output("reset_fill_busy", fill_busy, 0);
    check_output("reset_fill_done", fill_done, 0);
    check_output("reset_oob_err", oob_err, 0);
    check_output("reset_host_ready", host_ready, 1);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d_host_ready", i), host_ready, vecs[i].exp_ready);
      if (vecs[i].exp_we) push_write(vecs[i].exp_addr, vecs[i].exp_data);
      @(negedge clk);
      check_output($sformatf("vec%0d_fb_we", i), fb_we, vecs[i].exp_we);
      check_output($sformatf("vec%0d_oob_err", i), oob_err, vecs[i].exp_oob);
    end
    check_output("idle_hold_addr", fb_addr, 38160);
    check_output("idle_hold_data", fb_wdata, 18'h00F0F);

    $display("[TB] host stalled by GBA");
    host_valid = 1; host_x = 239; host_y = 159; host_data = 18'h0ABCD;
    for (int i = 0; i < 3; i++) begin
      gba_we = 1; gba_x = 8'(i); gba_y = 1; gba_data = 18'(i + 1);
      push_write(pix(i, 1), 18'(i + 1));
      #1;
      check_output($sformatf("stall%0d_host_ready", i), host_ready, 0);
      @(negedge clk);
    end
    gba_we = 0;
    push_write(16'd38399, 18'h0ABCD);
    #1;
    check_output("stall_release_ready", host_ready, 1);
    @(negedge clk);
    host_valid = 0;
    check_output("stall_host_addr", fb_addr, 38399);
    @(negedge clk);

    $display("[TB] clipped fill, no contention");
    busy_cycles = 0; done_count = 0;
    push_write(16'd38158, 18'h00FFF);
    push_write(16'd38159, 18'h00FFF);
    push_write(16'd38398, 18'h00FFF);
    push_write(16'd38399, 18'h00FFF);
    start_fill(238, 158, 5, 5, 18'h00FFF);
    wait_fill_idle("fill1_timeout");
    @(negedge clk);
    check_output("fill1_busy_cycles", busy_cycles, 4);
    check_output("fill1_done_count", done_count, 1);
    check_output("fill1_done_with_we", done_we, 1);
    check_output("fill1_done_addr", done_addr, 38399);

    $display("[TB] clipped fill with GBA interleave");
    busy_cycles = 0; done_count = 0;
    push_write(16'd38158, 18'h00FFF);
    push_write(pix(1, 1), 18'h11111);
    push_write(pix(2, 1), 18'h22222);
    push_write(16'd38159, 18'h00FFF);
    push_write(16'd38398, 18'h00FFF);
    push_write(16'd38399, 18'h00FFF);
    start_fill(238, 158, 5, 5, 18'h00FFF);
    @(negedge clk);
    gba_we = 1; gba_x = 1; gba_y = 1; gba_data = 18'h11111;
    @(negedge clk);
    gba_x = 2; gba_data = 18'h22222;
    @(negedge clk);
    gba_we = 0;
    wait_fill_idle("fill2_timeout");
    @(negedge clk);
    check_output("fill2_busy_cycles", busy_cycles, 6);
    check_output("fill2_done_count", done_count, 1);
    check_output("fill2_pending", sb_q.size(), 0);

    $display("[TB] fill abort");
    busy_cycles = 0; done_count = 0;
    for (int i = 0; i < 8; i++) push_write(pix(i, 0), 18'h0C0C0);
    start_fill(0, 0, 100, 100, 18'h0C0C0);
    repeat (7) @(negedge clk);
    fill_abort = 1;
    @(negedge clk);
    fill_abort = 0;
    check_output("abort_busy_low", fill_busy, 0);
    repeat (5) @(negedge clk);
    check_output("abort_done_count", done_count, 0);
    check_output("abort_writes_left", sb_q.size(), 0);
    check_output("abort_busy_cycles", busy_cycles, 8);

    $display("[TB] start and abort together in idle");
    done_count = 0;
    push_write(16'd5, 18'h3C3C3);
    fill_abort = 1;
    start_fill(5, 0, 1, 1, 18'h3C3C3);
    fill_abort = 0;
    check_output("start_wins_busy", fill_busy, 1);
    wait_fill_idle("start_wins_timeout");
    @(negedge clk);
    check_output("start_wins_done", done_count, 1);

    $display("[TB] out of range and degenerate fill");
    gba_we = 1; gba_x = 240; gba_y = 0; gba_data = 18'h3FFFF;
    @(negedge clk);
    gba_we = 0;
    check_output("oob_gba_we", fb_we, 0);
    check_output("oob_gba_flag", oob_err, 1);
    host_valid = 1; host_x = 3; host_y = 160; host_data = 18'h00003;
    #1;
    check_output("oob_host_ready", host_ready, 1);
    @(negedge clk);
    host_valid = 0;
    check_output("oob_host_we", fb_we, 0);
    done_count = 0;
    start_fill(0, 0, 0, 5, 18'h11111);
    check_output("degen_done_pulse", fill_done, 1);
    check_output("degen_busy", fill_busy, 0);
    @(negedge clk);
    check_output("degen_done_clear", fill_done, 0);
    check_output("oob_sticky", oob_err, 1);
    repeat (3) @(negedge clk);
    check_output("degen_done_count", done_count, 1);
    check_output("final_pending", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
